approx_add_pipe: RTL and testbench

APPROX_ADD_PIPE -- requirements
Module: approx_add_pipe

---
 rtl/approx_pkg.sv | 23 ++
 rtl/approx_add_pipe_if.sv | 30 +++
 rtl/approx_add_seg.sv | 43 ++++
 rtl/approx_add_pipe.sv | 159 +++++++++++++++
 tb/tb_approx_add_pipe.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder pipeline: mode encoding and
// the helpers that split the carry chain into near-equal segments.
package approx_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Width of segment idx; the remainder bits go to the lowest segments.
  function automatic int seg_width(input int width, input int stages, input int idx);
    return width / stages + ((idx < (width % stages)) ? 1 : 0);
  endfunction

  // Bit position where segment idx starts.
  function automatic int seg_lo(input int width, input int stages, input int idx);
    int lo;
    lo = 0;
    for (int i = 0; i < idx; i++) begin
      lo += seg_width(width, stages, i);
    end
    return lo;
  endfunction

endpackage

// File: rtl/approx_add_pipe_if.sv
// Operand/result bundle for approx_add_pipe.
// Handshake: a beat moves when in_valid & in_ready, a result moves when
// out_valid & out_ready; a source holds its payload stable until it moves.
interface approx_add_pipe_if #(
  parameter int WIDTH = 12
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             mode_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum_o;
  logic [WIDTH:0]   err_o;
  logic [WIDTH:0]   wce_o;
  logic [31:0]      err_cnt_o;

  modport master (
    output in_valid, a_i, b_i, mode_i, out_ready,
    input  in_ready, out_valid, sum_o, err_o, wce_o, err_cnt_o
  );

  modport slave (
    input  in_valid, a_i, b_i, mode_i, out_ready,
    output in_ready, out_valid, sum_o, err_o, wce_o, err_cnt_o
  );

endinterface

// File: rtl/approx_add_seg.sv
// One carry segment: exact ripple sum and lower-part-OR approximate sum side
// by side, each with its own carry in and carry out.
module approx_add_seg
  import approx_pkg::*;
#(
  parameter int SEG_W    = 6,
  parameter int LO       = 0,
  parameter int APPROX_K = 5
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ex_cin,
  input  logic             ap_cin,
  output logic [SEG_W-1:0] ex_sum,
  output logic [SEG_W-1:0] ap_sum,
  output logic             ex_cout,
  output logic             ap_cout
);

  always_comb begin
    logic ec;
    logic ac;
    ec     = ex_cin;
    ac     = ap_cin;
    ex_sum = '0;
    ap_sum = '0;
    for (int i = 0; i < SEG_W; i++) begin
      ex_sum[i] = a[i] ^ b[i] ^ ec;
      ec        = (a[i] & b[i]) | (ec & (a[i] ^ b[i]));
      if (LO + i < APPROX_K) begin
        // Lower part: OR only; the top approximated bit of B feeds the upper carry.
        ap_sum[i] = a[i] | b[i];
        ac        = (LO + i == APPROX_K - 1) ? b[i] : 1'b0;
      end else begin
        ap_sum[i] = a[i] ^ b[i] ^ ac;
        ac        = (a[i] & b[i]) | (ac & (a[i] ^ b[i]));
      end
    end
    ex_cout = ec;
    ap_cout = ac;
  end

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined exact/approximate adder: the carry chain is cut into STAGES
// registered segments; the exact sum rides along to produce err/wce/err_cnt.
module approx_add_pipe
  import approx_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int APPROX_K = 5,
  parameter int STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mode_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum_o,
  output logic [WIDTH:0]   err_o,
  output logic [WIDTH:0]   wce_o,
  output logic [31:0]      err_cnt_o
);

  localparam int LAST = STAGES - 1;

  logic advance;

  // Stage registers
  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic             r_mode  [STAGES];
  logic [WIDTH:0]   r_ex    [STAGES];
  logic [WIDTH:0]   r_ap    [STAGES];
  logic             r_exc   [STAGES];
  logic             r_apc   [STAGES];

  // What each stage sees on its input side, and what it will register
  logic             s_valid [STAGES];
  logic [WIDTH-1:0] s_a     [STAGES];
  logic [WIDTH-1:0] s_b     [STAGES];
  logic             s_mode  [STAGES];
  logic [WIDTH:0]   s_ex    [STAGES];
  logic [WIDTH:0]   s_ap    [STAGES];
  logic             s_exc   [STAGES];
  logic             s_apc   [STAGES];
  logic [WIDTH:0]   n_ex    [STAGES];
  logic [WIDTH:0]   n_ap    [STAGES];
  logic             n_exc   [STAGES];
  logic             n_apc   [STAGES];

  // The whole pipe moves or holds as one; bubbles travel as invalid stages.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    s_valid[0] = in_valid;
    s_a[0]     = a_i;
    s_b[0]     = b_i;
    s_mode[0]  = mode_i;
    s_ex[0]    = '0;
    s_ap[0]    = '0;
    s_exc[0]   = 1'b0;
    s_apc[0]   = 1'b0;
    for (int s = 1; s < STAGES; s++) begin
      s_valid[s] = r_valid[s-1];
      s_a[s]     = r_a[s-1];
      s_b[s]     = r_b[s-1];
      s_mode[s]  = r_mode[s-1];
      s_ex[s]    = r_ex[s-1];
      s_ap[s]    = r_ap[s-1];
      s_exc[s]   = r_exc[s-1];
      s_apc[s]   = r_apc[s-1];
    end
  end

  for (genvar gs = 0; gs < STAGES; gs++) begin : g_stage
    localparam int LO = seg_lo(WIDTH, STAGES, gs);
    localparam int SW = seg_width(WIDTH, STAGES, gs);

    logic [SW-1:0] seg_ex;
    logic [SW-1:0] seg_ap;
    logic          exc;
    logic          apc;

    approx_add_seg #(
      .SEG_W   (SW),
      .LO      (LO),
      .APPROX_K(APPROX_K)
    ) u_seg (
      .a      (s_a[gs][LO +: SW]),
      .b      (s_b[gs][LO +: SW]),
      .ex_cin (s_exc[gs]),
      .ap_cin (s_apc[gs]),
      .ex_sum (seg_ex),
      .ap_sum (seg_ap),
      .ex_cout(exc),
      .ap_cout(apc)
    );

    // The final segment folds its carry out into the result MSB.
    if (gs == LAST) begin : g_last
      assign n_ex[gs] = s_ex[gs] | ((WIDTH+1)'({exc, seg_ex}) << LO);
      assign n_ap[gs] = s_ap[gs] | ((WIDTH+1)'({apc, seg_ap}) << LO);
    end else begin : g_mid
      assign n_ex[gs] = s_ex[gs] | ((WIDTH+1)'(seg_ex) << LO);
      assign n_ap[gs] = s_ap[gs] | ((WIDTH+1)'(seg_ap) << LO);
    end
    assign n_exc[gs] = exc;
    assign n_apc[gs] = apc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_a[s]     <= '0;
        r_b[s]     <= '0;
        r_mode[s]  <= MODE_EXACT;
        r_ex[s]    <= '0;
        r_ap[s]    <= '0;
        r_exc[s]   <= 1'b0;
        r_apc[s]   <= 1'b0;
      end
    end else if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= s_valid[s];
        r_a[s]     <= s_a[s];
        r_b[s]     <= s_b[s];
        r_mode[s]  <= s_mode[s];
        r_ex[s]    <= n_ex[s];
        r_ap[s]    <= n_ap[s];
        r_exc[s]   <= n_exc[s];
        r_apc[s]   <= n_apc[s];
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum_o     = (r_mode[LAST] == MODE_APPROX) ? r_ap[LAST] : r_ex[LAST];
  assign err_o     = (sum_o >= r_ex[LAST]) ? (sum_o - r_ex[LAST]) : (r_ex[LAST] - sum_o);

  // Error statistics count delivered results only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wce_o     <= '0;
      err_cnt_o <= '0;
    end else if (out_valid && out_ready) begin
      if (err_o > wce_o) begin
        wce_o <= err_o;
      end
      if ((err_o != '0) && (err_cnt_o != 32'hFFFF_FFFF)) begin
        err_cnt_o <= err_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe: vector table, latency/stall/reset sequences and
// a random backpressure run, all checked through an expected-result queue.
module tb_approx_add_pipe;
  import approx_pkg::*;

  localparam int WIDTH    = 12;
  localparam int APPROX_K = 5;
  localparam int STAGES   = 2;
  localparam int RW       = WIDTH + 1;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic [RW-1:0]    sum;
    logic [RW-1:0]    err;
  } vec_t;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  approx_add_pipe_if #(.WIDTH(WIDTH)) bus ();

  approx_add_pipe #(
    .WIDTH   (WIDTH),
    .APPROX_K(APPROX_K),
    .STAGES  (STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .a_i      (bus.a_i),
    .b_i      (bus.b_i),
    .mode_i   (bus.mode_i),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .sum_o    (bus.sum_o),
    .err_o    (bus.err_o),
    .wce_o    (bus.wce_o),
    .err_cnt_o(bus.err_cnt_o)
  );

  vec_t            vecs [7];
  logic [2*RW-1:0] exp_q[$];
  logic [2*RW-1:0] mon_e;
  logic [2*RW-1:0] head_e;
  logic [RW-1:0]   m_wce;
  logic [31:0]     m_cnt;
  int              checks = 0;
  int              errors = 0;
  bit              rnd_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model written from the arithmetic definition.
  function automatic logic [RW-1:0] model_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic mode);
    logic [RW-1:0] lo_mask;
    logic [RW-1:0] hi;
    if (mode == MODE_EXACT) return RW'(a) + RW'(b);
    lo_mask = (RW'(1) << APPROX_K) - RW'(1);
    hi      = RW'(a >> APPROX_K) + RW'(b >> APPROX_K) + RW'(b[APPROX_K-1]);
    return (hi << APPROX_K) | ((RW'(a) | RW'(b)) & lo_mask);
  endfunction

  function automatic logic [RW-1:0] model_err(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic mode);
    logic [RW-1:0] ex;
    logic [RW-1:0] s;
    ex = RW'(a) + RW'(b);
    s  = model_sum(a, b, mode);
    return (s >= ex) ? (s - ex) : (ex - s);
  endfunction

  // Driver: call at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic mode,
                      input logic [RW-1:0] es, input logic [RW-1:0] ee);
    int n;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.mode_i   = mode;
    #1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 after %0d cycles, expected 1", n);
    end else begin
      exp_q.push_back({es, ee});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic mode);
    send(a, b, mode, model_sum(a, b, mode), model_err(a, b, mode));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
    end
  endtask

  // Call at a falling edge; presents a junk beat during reset to prove it is dropped.
  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a_i      = 12'h123;
    bus.b_i      = 12'h456;
    bus.mode_i   = MODE_APPROX;
    @(negedge clk);
    #2;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sum", bus.sum_o, '0);
    check("rst_err", bus.err_o, '0);
    check("rst_wce", bus.wce_o, '0);
    check("rst_cnt", bus.err_cnt_o, '0);
    exp_q.delete();
    m_wce = '0;
    m_cnt = '0;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    repeat (STAGES + 1) begin
      #2;
      check("post_rst_out_valid", bus.out_valid, 1'b0);
      @(negedge clk);
    end
  endtask

  // Scoreboard: compare every delivered result against the queue head.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("wce_before_xfer", bus.wce_o, m_wce);
      check("cnt_before_xfer", bus.err_cnt_o, m_cnt);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got sum 0x%0h, expected no result", bus.sum_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", bus.sum_o, mon_e[2*RW-1:RW]);
        check("err", bus.err_o, mon_e[RW-1:0]);
        if (mon_e[RW-1:0] > m_wce) m_wce = mon_e[RW-1:0];
        if (mon_e[RW-1:0] != '0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, expected finish earlier");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    bus.mode_i    = MODE_EXACT;
    bus.out_ready = 1'b1;
    m_wce         = '0;
    m_cnt         = '0;
    rnd_done      = 1'b0;

    vecs[0] = '{a: 12'h010, b: 12'h010, mode: MODE_APPROX, sum: 13'h0030, err: 13'h0010};
    vecs[1] = '{a: 12'hFFF, b: 12'hFFF, mode: MODE_APPROX, sum: 13'h1FFF, err: 13'h0001};
    vecs[2] = '{a: 12'hFFF, b: 12'h001, mode: MODE_EXACT,  sum: 13'h1000, err: 13'h0000};
    vecs[3] = '{a: 12'hABC, b: 12'h123, mode: MODE_APPROX, sum: 13'h0BDF, err: 13'h0000};
    vecs[4] = '{a: 12'h00F, b: 12'h011, mode: MODE_APPROX, sum: 13'h003F, err: 13'h001F};
    vecs[5] = '{a: 12'h000, b: 12'h000, mode: MODE_EXACT,  sum: 13'h0000, err: 13'h0000};
    vecs[6] = '{a: 12'h800, b: 12'h800, mode: MODE_EXACT,  sum: 13'h1000, err: 13'h0000};

    @(negedge clk);
    do_reset();

    // Table vectors, with statistics checked between groups
    for (int i = 0; i < 2; i++) send(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].sum, vecs[i].err);
    drain();
    #2;
    check("tbl_wce", bus.wce_o, 13'h0010);
    check("tbl_cnt", bus.err_cnt_o, 32'd2);
    @(negedge clk);
    send(vecs[2].a, vecs[2].b, vecs[2].mode, vecs[2].sum, vecs[2].err);
    drain();
    #2;
    check("exact_cnt_unchanged", bus.err_cnt_o, 32'd2);
    @(negedge clk);
    for (int i = 3; i < 7; i++) send(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].sum, vecs[i].err);
    drain();

    // Latency: result appears STAGES cycles after the accepting edge's cycle
    send(12'h01F, 12'h001, MODE_APPROX, 13'h001F, 13'h0001);
    #2;
    check("lat_early_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    #2;
    check("lat_valid", bus.out_valid, 1'b1);
    @(negedge clk);
    drain();

    // Stall: downstream blocks while beats keep coming
    fork
      begin
        send_model(12'h111, 12'h222, MODE_APPROX);
        send_model(12'h333, 12'h0F0, MODE_EXACT);
        send_model(12'h01F, 12'h01F, MODE_APPROX);
        send_model(12'hFFE, 12'h003, MODE_APPROX);
      end
      begin
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          #2;
          head_e = exp_q[0];
          check("stall_in_ready", bus.in_ready, 1'b0);
          check("stall_out_valid", bus.out_valid, 1'b1);
          check("stall_sum_hold", bus.sum_o, head_e[2*RW-1:RW]);
          check("stall_err_hold", bus.err_o, head_e[RW-1:0]);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random operands with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_model(WIDTH'($urandom_range(0, 4095)), WIDTH'($urandom_range(0, 4095)),
                     logic'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: nothing may come out afterwards
    bus.out_ready = 1'b0;
    send_model(12'h010, 12'h010, MODE_APPROX);
    send_model(12'h00F, 12'h011, MODE_APPROX);
    do_reset();
    bus.out_ready = 1'b1;
    repeat (4) begin
      #2;
      check("flush_out_valid", bus.out_valid, 1'b0);
      check("flush_wce", bus.wce_o, '0);
      check("flush_cnt", bus.err_cnt_o, '0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
